// File: rtl/ecall_write_streamer.sv
// Streams a byte buffer from data memory to an external device over a
// 4-phase strobe/ack handshake on behalf of a CPU write ecall.
module ecall_write_streamer #(
    parameter int MEMORY_BITS = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_ecall,
    input  logic [63:0]            write_ecall_address,
    input  logic [63:0]            write_ecall_len,
    output logic                   mem_rden,
    output logic [MEMORY_BITS-1:0] mem_addr,
    input  logic [63:0]            mem_q,
    output logic [7:0]             io_data,
    output logic                   io_strobe,
    input  logic                   io_ack,
    output logic                   write_ecall_finished,
    output logic                   busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    logic [MEMORY_BITS-1:0] addr_q;
    logic [63:0]            len_q;
    logic [63:0]            read_offset;
    logic [63:0]            remaining;
    logic [63:0]            sent_count;
    logic                   rd_pending;
    logic                   loaded;
    logic                   ack_m;
    logic                   ack_s;

    logic [7:0]             fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            occ;
    logic                   push;
    logic                   pop;

    logic                   unused_bits;
    assign unused_bits = ^{mem_q[63:8], write_ecall_address[63:MEMORY_BITS],
                           read_offset[63:MEMORY_BITS]};

    // Occupancy counts the read still in flight so the FIFO can never overflow.
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending};
    assign mem_rden = (state == SEND) && (remaining != 64'd0) && (occ < DEPTH_W);
    assign mem_addr = addr_q + read_offset[MEMORY_BITS-1:0];
    assign push     = rd_pending;
    assign pop      = io_strobe && ack_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= io_ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_count == FULL_C)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            addr_q               <= '0;
            len_q                <= '0;
            read_offset          <= '0;
            remaining            <= '0;
            sent_count           <= '0;
            rd_pending           <= 1'b0;
            loaded               <= 1'b0;
            io_data              <= '0;
            io_strobe            <= 1'b0;
            write_ecall_finished <= 1'b1;
            busy                 <= 1'b0;
        end else begin
            rd_pending <= mem_rden;
            unique case (state)
                IDLE: begin
                    write_ecall_finished <= 1'b1;
                    busy                 <= 1'b0;
                    if (write_ecall) begin
                        addr_q               <= write_ecall_address[MEMORY_BITS-1:0];
                        len_q                <= write_ecall_len;
                        remaining            <= write_ecall_len;
                        read_offset          <= '0;
                        sent_count           <= '0;
                        loaded               <= 1'b0;
                        write_ecall_finished <= 1'b0;
                        if (write_ecall_len == 64'd0) begin
                            state <= DONE;
                        end else begin
                            state <= SEND;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (mem_rden) begin
                        remaining   <= remaining - 64'd1;
                        read_offset <= read_offset + 64'd1;
                    end
                    // Strobe/ack handshake: load, setup cycle, strobe, release.
                    if (io_strobe) begin
                        if (ack_s) begin
                            io_strobe  <= 1'b0;
                            loaded     <= 1'b0;
                            sent_count <= sent_count + 64'd1;
                        end
                    end else if (loaded) begin
                        io_strobe <= 1'b1;
                    end else if ((fifo_count != '0) && !ack_s) begin
                        io_data <= fifo_mem[rd_ptr];
                        loaded  <= 1'b1;
                    end
                    if (!io_strobe && !loaded && !ack_s && (sent_count == len_q)) begin
                        state                <= DONE;
                        write_ecall_finished <= 1'b1;
                        busy                 <= 1'b0;
                    end
                end
                DONE: begin
                    write_ecall_finished <= 1'b1;
                    busy                 <= 1'b0;
                    if (!write_ecall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
